// File: rtl/digital_channel_pkg.sv
// digital_channel_pkg
//   Shared types and constants for the per-channel digital controller.
//   - state_t    : controller FSM states
//   - GUARD_CYCLES: idle cycles after the CSA reset pulse so the hit
//                  synchronizer can flush a stale level
//   - packet_t   : packet layout {timestamp, adc} at the default widths
//   - pulse_load : turns a pulse length into a down-counter preload,
//                  treating a length of 0 as 1
package digital_channel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_WAIT,
    CONVERT,
    STORE,
    RESET_CSA,
    GUARD
  } state_t;

  localparam int GUARD_CYCLES = 2;

  localparam int DEF_ADCBITS = 10;
  localparam int DEF_TS_BITS = 24;

  typedef struct packed {
    logic [DEF_TS_BITS-1:0] ts;
    logic [DEF_ADCBITS-1:0] adc;
  } packet_t;

  // A counter loaded with N-1 and stepped until it reads 0 spans N cycles.
  function automatic logic [7:0] pulse_load(input logic [7:0] len);
    return (len == 8'd0) ? 8'd0 : len - 8'd1;
  endfunction

endpackage

// File: rtl/digital_channel_ctrl_fifo.sv
// channel_fifo
//   First-word-fall-through synchronous FIFO for channel event packets.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset (flushes)
//     i_push, i_data  : write request / data; ignored while full
//     i_pop           : consume head entry; ignored while empty
//     o_data          : head entry, forced to 0 while empty
//     o_full, o_empty : status from the pointer comparison
module channel_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit separates "full" from "empty" when the
  // address bits are equal.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which
  // entries are valid and o_data is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/digital_channel_ctrl.sv
// digital_channel_ctrl
//   Digital end of one analog channel: synchronizes hit/done, sequences
//   track/hold and CSA reset, captures {timestamp, adc} per event and
//   queues packets for the readout arbiter.
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     enable                : accept new hits when high
//     timestamp             : free-running chip timestamp
//     hold_delay            : cycles from hit detect to hold
//     reset_length          : csa_reset width (0 behaves as 1)
//     clear_flags           : clears overflow/timeout
//     hit, done             : asynchronous front-end / ADC strobes
//     dout                  : ADC result, stable while done is high
//     sample, csa_reset     : track(1)/hold(0), CSA re-arm
//     data_out, data_valid  : FIFO head packet and not-empty
//     data_ready            : consumer pops the head entry
//     overflow, timeout     : sticky error flags
//     busy                  : controller not idle
module digital_channel_ctrl
  import digital_channel_pkg::*;
#(
  parameter int ADCBITS        = 10,
  parameter int TS_BITS        = 24,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [TS_BITS-1:0]         timestamp,
  input  logic [3:0]                 hold_delay,
  input  logic [7:0]                 reset_length,
  input  logic                       clear_flags,
  input  logic                       hit,
  input  logic                       done,
  input  logic [ADCBITS-1:0]         dout,
  output logic                       sample,
  output logic                       csa_reset,
  output logic [TS_BITS+ADCBITS-1:0] data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       overflow,
  output logic                       timeout,
  output logic                       busy
);

  // The shared down-counter must hold TIMEOUT_CYCLES and an 8-bit pulse length.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(GUARD_CYCLES - 1);

  // Synchronizers: flops 1-2 resolve metastability, flop 3 is the edge detector.
  logic r_hit_m, r_hit_s, r_hit_s_d;
  logic r_done_m, r_done_s, r_done_s_d;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [TS_BITS-1:0] r_ts_q;
  logic [ADCBITS-1:0] r_adc_q;
  logic               r_sample;
  logic               r_csa_reset;
  logic               r_busy;
  logic               r_overflow;
  logic               r_timeout;

  logic               w_hit_rise;
  logic               w_done_rise;
  logic [CNT_W-1:0]   w_rst_load;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_push;
  logic               w_overflow_set;
  logic               w_timeout_set;

  assign w_hit_rise     = r_hit_s && !r_hit_s_d;
  assign w_done_rise    = r_done_s && !r_done_s_d;
  assign w_rst_load     = CNT_W'(pulse_load(reset_length));
  // Full is judged before any same-cycle pop, so a store into a full
  // FIFO is always dropped.
  assign w_push         = (r_state == STORE) && !w_fifo_full;
  assign w_overflow_set = (r_state == STORE) && w_fifo_full;
  assign w_timeout_set  = (r_state == CONVERT) && !w_done_rise && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_m    <= 1'b0;
      r_hit_s    <= 1'b0;
      r_hit_s_d  <= 1'b0;
      r_done_m   <= 1'b0;
      r_done_s   <= 1'b0;
      r_done_s_d <= 1'b0;
    end else begin
      r_hit_m    <= hit;
      r_hit_s    <= r_hit_m;
      r_hit_s_d  <= r_hit_s;
      r_done_m   <= done;
      r_done_s   <= r_done_m;
      r_done_s_d <= r_done_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Leaving reset runs a full CSA reset pulse before accepting hits.
      r_state     <= RESET_CSA;
      r_cnt       <= w_rst_load;
      r_ts_q      <= '0;
      r_adc_q     <= '0;
      r_sample    <= 1'b1;
      r_csa_reset <= 1'b1;
      r_busy      <= 1'b1;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      // Setting a flag takes priority over a same-cycle clear.
      if (w_overflow_set)   r_overflow <= 1'b1;
      else if (clear_flags) r_overflow <= 1'b0;
      if (w_timeout_set)    r_timeout  <= 1'b1;
      else if (clear_flags) r_timeout  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_hit_rise && enable) begin
            r_ts_q  <= timestamp;
            r_cnt   <= CNT_W'(hold_delay);
            r_busy  <= 1'b1;
            r_state <= HOLD_WAIT;
          end
        end
        HOLD_WAIT: begin
          if (r_cnt == '0) begin
            r_sample <= 1'b0;
            r_cnt    <= TIMEOUT_LOAD;
            r_state  <= CONVERT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CONVERT: begin
          if (w_done_rise) begin
            r_adc_q <= dout;
            r_state <= STORE;
          end else if (r_cnt == '0) begin
            r_sample    <= 1'b1;
            r_csa_reset <= 1'b1;
            r_cnt       <= w_rst_load;
            r_state     <= RESET_CSA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STORE: begin
          r_sample    <= 1'b1;
          r_csa_reset <= 1'b1;
          r_cnt       <= w_rst_load;
          r_state     <= RESET_CSA;
        end
        RESET_CSA: begin
          if (r_cnt == '0) begin
            r_csa_reset <= 1'b0;
            r_cnt       <= GUARD_LOAD;
            r_state     <= GUARD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GUARD: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_sample    <= 1'b1;
          r_csa_reset <= 1'b1;
          r_busy      <= 1'b1;
          r_cnt       <= w_rst_load;
          r_state     <= RESET_CSA;
        end
      endcase
    end
  end

  channel_fifo #(
    .WIDTH (TS_BITS + ADCBITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({r_ts_q, r_adc_q}),
    .i_pop   (data_ready),
    .o_data  (data_out),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign data_valid = !w_fifo_empty;
  assign sample     = r_sample;
  assign csa_reset  = r_csa_reset;
  assign busy       = r_busy;
  assign overflow   = r_overflow;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_digital_channel_ctrl.sv
module tb_digital_channel_ctrl;

  localparam int ADCBITS        = 10;
  localparam int TS_BITS        = 24;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int PW             = TS_BITS + ADCBITS;

  logic               clk = 1'b0;
  logic               reset, enable, clear_flags, hit, done, data_ready;
  logic [TS_BITS-1:0] timestamp;
  logic [3:0]         hold_delay;
  logic [7:0]         reset_length;
  logic [ADCBITS-1:0] dout;
  logic               sample, csa_reset, data_valid, overflow, timeout, busy;
  logic [PW-1:0]      data_out;

  int                 cyc = 0;
  int                 n_checks = 0;
  int                 n_fail = 0;
  logic [TS_BITS-1:0] ts_off = '0;
  logic [PW-1:0]      exp_q[$];
  logic               exp_ovf = 1'b0;

  always #5 clk = ~clk;
  // cyc equals the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  digital_channel_ctrl #(
    .ADCBITS(ADCBITS), .TS_BITS(TS_BITS),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .timestamp(timestamp),
    .hold_delay(hold_delay), .reset_length(reset_length),
    .clear_flags(clear_flags), .hit(hit), .done(done), .dout(dout),
    .sample(sample), .csa_reset(csa_reset), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready),
    .overflow(overflow), .timeout(timeout), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Timestamp model: value presented at edge N is ts_off + N.
  task automatic set_ts_now();
    timestamp = ts_off + TS_BITS'(cyc + 1);
  endtask

  task automatic step();
    @(negedge clk);
    set_ts_now();
  endtask

  task automatic csa_pulse(output int n);
    n = 0;
    while (csa_reset === 1'b1 && n < 300) begin
      n++;
      step();
    end
  endtask

  // Called at the first cycle csa_reset is observed low: GUARD spans 2 cycles.
  task automatic guard_check();
    check("guard_busy_a", busy, 1);
    check("guard_sample", sample, 1);
    step();
    check("guard_busy_b", busy, 1);
    step();
    check("guard_idle", busy, 0);
  endtask

  task automatic run_event(input logic [3:0] hd, input int dly, input logic [9:0] adc,
                           input logic give_done, input logic extra, input logic [7:0] rl);
    int k, d, n;
    logic was_empty;
    logic [PW-1:0] pkt;
    set_ts_now();
    hold_delay   = hd;
    reset_length = rl;
    dout         = adc;
    hit          = 1'b1;
    k            = cyc + 1;
    step();
    step();
    hit = 1'b0;
    n = 0;
    while (sample === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check("sample_fall", sample, 0);
    check("hit_latency", cyc, k + 3 + int'(hd));
    pkt = {ts_off + TS_BITS'(k + 2), adc};
    if (extra) begin
      // A pulse during CONVERT, then a level held through the rest of the event.
      hit = 1'b1;
      step();
      step();
      hit = 1'b0;
      repeat (3) step();
      hit = 1'b1;
    end
    if (give_done) begin
      repeat (dly) step();
      done      = 1'b1;
      d         = cyc + 1;
      was_empty = (exp_q.size() == 0);
      repeat (3) step();
      done = 1'b0;
      check("store_csa_low", csa_reset, 0);
      check("store_edge", cyc, d + 2);
      step();
      check("push_csa_high", csa_reset, 1);
      check("push_sample_high", sample, 1);
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(pkt);
      else exp_ovf = 1'b1;
      if (was_empty) check("valid_after_push", data_valid, 1);
      check("overflow_flag", overflow, exp_ovf);
    end else begin
      n = 0;
      while (sample === 1'b0 && n < 400) begin
        n++;
        step();
      end
      check("timeout_low_cycles", n, TIMEOUT_CYCLES + 1);
      check("timeout_flag", timeout, 1);
      check("timeout_csa_high", csa_reset, 1);
    end
    csa_pulse(n);
    check("csa_pulse_len", n, (rl == 8'd0) ? 1 : int'(rl));
    guard_check();
  endtask

  task automatic drain();
    data_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("drain_valid", data_valid, 1);
      check("drain_data", data_out, exp_q.pop_front());
      step();
    end
    data_ready = 1'b0;
    check("drain_empty", data_valid, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b1; clear_flags = 1'b0; hit = 1'b0; done = 1'b0;
    data_ready = 1'b0; hold_delay = '0; reset_length = 8'd8; dout = '0;
    timestamp = '0;

    // Reset values
    repeat (3) step();
    check("rst_sample", sample, 1);
    check("rst_csa", csa_reset, 1);
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;
    csa_pulse(n);
    check("rst_csa_pulse", n, 8);
    guard_check();

    // Basic event: hold_delay 0, timestamp 1000 at detect, done 10 cycles later
    step();
    ts_off = TS_BITS'(1000 - (cyc + 3));
    run_event(4'd0, 10, 10'h2A5, 1'b1, 1'b0, 8'd8);
    check("pkt1", data_out, {24'd1000, 10'h2A5});
    drain();

    // Timeout: no done
    ts_off = TS_BITS'($urandom);
    run_event(4'(($urandom_range(0, 15))), 0, 10'h000, 1'b0, 1'b0, 8'd8);
    check("timeout_no_pkt", data_valid, 0);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("timeout_cleared", timeout, 0);

    // Overflow: five events into a four-deep FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      ts_off = TS_BITS'($urandom);
      run_event(4'($urandom_range(0, 15)), $urandom_range(0, 20), 10'($urandom),
                1'b1, 1'b0, (i == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
      step();
    end
    check("overflow_set", overflow, 1);
    drain();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    exp_ovf = 1'b0;
    check("overflow_cleared", overflow, 0);

    // Hits outside IDLE are ignored
    ts_off = TS_BITS'($urandom);
    run_event(4'd3, 5, 10'($urandom), 1'b1, 1'b1, 8'd4);
    repeat (10) step();
    check("held_hit_idle", busy, 0);
    check("held_hit_sample", sample, 1);
    check("held_hit_one_pkt", data_valid, 1);
    hit = 1'b0;
    repeat (3) step();
    ts_off = TS_BITS'($urandom);
    run_event(4'd1, 3, 10'($urandom), 1'b1, 1'b0, 8'd2);
    drain();

    // Disabled channel
    enable = 1'b0;
    hit = 1'b1;
    step();
    step();
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("dis_busy", busy, 0);
      check("dis_sample", sample, 1);
    end
    check("dis_no_pkt", data_valid, 0);
    enable = 1'b1;
    step();

    // Reset mid-CONVERT with two packets queued
    for (int i = 0; i < 2; i++) begin
      ts_off = TS_BITS'($urandom);
      run_event(4'($urandom_range(0, 15)), $urandom_range(0, 20), 10'($urandom),
                1'b1, 1'b0, 8'd8);
      step();
    end
    check("pre_reset_valid", data_valid, 1);
    hold_delay = 4'd2;
    reset_length = 8'd8;
    hit = 1'b1;
    step();
    step();
    hit = 1'b0;
    n = 0;
    while (sample === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check("mid_sample_low", sample, 0);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_csa", csa_reset, 1);
    check("mid_rst_sample", sample, 1);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_data", data_out, 0);
    csa_pulse(n);
    check("mid_rst_pulse", n, 8);
    guard_check();
    step();
    ts_off = TS_BITS'($urandom);
    run_event(4'd5, 7, 10'($urandom), 1'b1, 1'b0, 8'd3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digital_channel_ctrl.md
# digital_channel_ctrl

Per-channel digital controller: the digital end of one analog channel's hit/sample/ADC/reset handshake. One instance per channel. The block:
- synchronizes the asynchronous `hit` and `done` from the analog front end;
- drives `sample` (track/hold) and `csa_reset`;
- captures the ADC word and a timestamp for each event;
- buffers the packets in a small FIFO for the chip-level readout arbiter.

## Interface
Parameters:
- `ADCBITS`, 10, ADC word width
- `TS_BITS`, 24, timestamp width
- `FIFO_DEPTH`, 4, event buffer entries; power of 2, ≥2
- `TIMEOUT_CYCLES`, 255, maximum wait for `done` after hold

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  channel enable; when low, new hits are ignored
- `timestamp`  in  TS_BITS  free-running chip timestamp
- `hold_delay`  in  4  cycles between detected hit and `sample` falling
- `reset_length`  in  8  `csa_reset` pulse width in cycles; 0 is treated as 1
- `clear_flags`  in  1  clears the sticky flags
- `hit`  in  1  asynchronous discriminator output
- `done`  in  1  asynchronous ADC conversion complete
- `dout`  in  ADCBITS  ADC result; stable while `done` is high
- `sample`  out  1  1 = track, 0 = hold
- `csa_reset`  out  1  CSA reset / re-arm
- `data_out`  out  TS_BITS+ADCBITS  packet {timestamp, adc}
- `data_valid`  out  1  FIFO not empty
- `data_ready`  in  1  consumer accepts the head entry
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full
- `timeout`  out  1  sticky: `done` was not seen within TIMEOUT_CYCLES
- `busy`  out  1  FSM not in IDLE

## Operation
- `hit` and `done` each pass through a 2-flop synchronizer, producing `hit_s` and `done_s`. The FSM acts on their rising edges (a 3rd flop supplies the edge detect).
- **IDLE** (`sample`=1, `csa_reset`=0): on a `hit_s` rise with `enable`=1:
  - latch `timestamp` into `ts_q`;
  - load the counter with `hold_delay`;
  - go to HOLD_WAIT.
- **HOLD_WAIT**: decrement the counter. When the counter is 0, drive `sample`=0, load the counter with TIMEOUT_CYCLES, and go to CONVERT. With `hold_delay`=0 this state lasts exactly 1 cycle.
- **CONVERT** (`sample`=0):
  - On a `done_s` rise: latch `dout`, go to STORE.
  - Else, when the counter reaches 0: set `timeout`, go to RESET_CSA without storing.
- **STORE** (1 cycle): push {`ts_q`, adc} into the FIFO if it is not full; otherwise drop the event and set `overflow`. Go to RESET_CSA.
- **RESET_CSA** (`sample`=1, `csa_reset`=1): hold for max(`reset_length`,1) cycles, then go to GUARD.
- **GUARD** (2 cycles, `csa_reset`=0): lets the synchronizers flush a stale `hit`. Then go to IDLE.
- Hits arriving outside IDLE are ignored.
- `enable` falling mid-event does not abort the event in progress.
- FIFO behaviour:
  - first-word-fall-through: `data_out` is the head entry, `data_valid` = !empty;
  - pop on `data_valid && data_ready`;
  - full is evaluated before the same-cycle pop, so a push while full is dropped even if a pop occurs in that cycle.
- `overflow` and `timeout` are cleared by `reset` or `clear_flags`. If a set event and `clear_flags` occur in the same cycle, set wins.

## Timing
- Reset: all outputs are registered. Reset values:
  - `sample`=1, `csa_reset`=1, `data_valid`=0, `data_out`=0;
  - `overflow`=0, `timeout`=0, `busy`=1;
  - FIFO empty, synchronizers 0.
- After `reset` deasserts, the FSM starts in RESET_CSA and runs a full `reset_length` pulse, then GUARD, then IDLE.
- Hit latency: `hit` sampled high at edge k gives:
  - `hit_s` rise detected at edge k+2;
  - `ts_q` = `timestamp` at edge k+2;
  - `sample` low after edge k+3+`hold_delay`.
- Done latency: `done` sampled high at edge d gives ADC latched at edge d+2, push at edge d+3, `data_valid` high after edge d+3 (FIFO previously empty).
- `csa_reset` rises after edge d+3 (same edge as the push).
- Timeout: `sample` is low for exactly TIMEOUT_CYCLES+1 cycles before `timeout` sets.
- Counters and pointers wrap modulo their width. FIFO pointers are log2(FIFO_DEPTH)+1 bits to distinguish full from empty.
- Synchronous `reset` mid-event aborts it immediately and flushes the FIFO. Packets in the FIFO are lost.

## Structure
- Package `digital_channel_pkg`:
  - state enum `{IDLE, HOLD_WAIT, CONVERT, STORE, RESET_CSA, GUARD}`;
  - `GUARD_CYCLES`=2;
  - packet typedef.
- One sub-module, `channel_fifo`: a parameterized FWFT synchronous FIFO with full/empty.
- Synchronizers are inline flops in the top.

## Test plan
- Reset, then `hit` pulse with `hold_delay`=0, `dout`=0x2A5, `done` 10 cycles after `sample` falls, `timestamp`=1000 at detect → `sample` low at k+3; one packet {1000, 0x2A5}; `csa_reset` high for `reset_length`=8 cycles.
- Withhold `done` → `sample` low for 256 cycles, `timeout`=1, no packet, `csa_reset` pulse follows; `clear_flags` clears `timeout`.
- Hold `data_ready`=0 and send 5 events into FIFO_DEPTH=4 → 4 packets in order, `overflow`=1. Then `data_ready`=1 → 4 pops, `data_valid` falls.
- Second `hit` during CONVERT, and a `hit` held high through RESET_CSA/GUARD → no extra event; next clean `hit` produces exactly one packet.
- `enable`=0 with a `hit` → no state change, `busy`=0, `sample`=1.
- Assert `reset` mid-CONVERT with 2 packets queued → next cycle `data_valid`=0, `csa_reset`=1, `sample`=1; normal operation resumes after RESET_CSA+GUARD.
